// File: rtl/servo_pwm_pkg.sv
// Shared defaults and helpers for the multi-channel servo PWM generator.
// Default constants target a 27 MHz clock and standard 50 Hz hobby servos.
package servo_pwm_pkg;

  localparam int unsigned DEF_NUM_CH     = 3;
  localparam int unsigned DEF_CLK_PER_US = 27;
  localparam int unsigned DEF_FRAME_US   = 20000;
  localparam int unsigned DEF_MIN_US     = 1000;
  localparam int unsigned DEF_MAX_US     = 2000;
  localparam int unsigned DEF_CENTER_US  = 1500;
  localparam int unsigned DEF_STAGGER_US = 0;
  localparam int unsigned DEF_US_W       = 16;

  function automatic int unsigned clamp_us(input int unsigned val,
                                           input int unsigned lo,
                                           input int unsigned hi);
    if (val < lo) return lo;
    if (val > hi) return hi;
    return val;
  endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Pulse-width write port: one-cycle strobe, target channel, width in microseconds.
interface servo_pwm_multi_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned US_W   = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic            wr_en;
  logic [CH_W-1:0] wr_ch;
  logic [US_W-1:0] wr_us;

  modport master (output wr_en, wr_ch, wr_us);
  modport slave  (input  wr_en, wr_ch, wr_us);
endinterface

// File: rtl/servo_pwm_channel.sv
// One servo channel: double-buffered pulse width, frame-latched enable and
// the registered window comparator against the shared microsecond counter.
module servo_pwm_channel
  import servo_pwm_pkg::*;
#(
  parameter int unsigned US_W      = DEF_US_W,
  parameter int unsigned MIN_US    = DEF_MIN_US,
  parameter int unsigned MAX_US    = DEF_MAX_US,
  parameter int unsigned CENTER_US = DEF_CENTER_US,
  parameter int unsigned OFF_US    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [US_W-1:0] us_cnt,
  input  logic            fb,
  input  logic            wr_sel,
  input  logic [US_W-1:0] wr_us,
  input  logic            ch_en,
  output logic            pwm
);

  logic [US_W-1:0] pending_reg;
  logic [US_W-1:0] active_reg;
  logic            en_act_reg;
  logic            pwm_reg;
  logic [US_W-1:0] clamped;
  logic [US_W-1:0] win_end;
  logic            above_off;
  logic            pwm_next;

  assign clamped = US_W'(clamp_us(32'(wr_us), MIN_US, MAX_US));
  assign win_end = US_W'(OFF_US) + active_reg;

  if (OFF_US == 0) begin : g_no_off
    assign above_off = 1'b1;
  end else begin : g_off
    assign above_off = (us_cnt >= US_W'(OFF_US));
  end

  assign pwm_next = en_act_reg && above_off && (us_cnt < win_end);

  // active only ever reloads at the frame boundary, so a pulse in flight never changes width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= US_W'(CENTER_US);
      active_reg  <= US_W'(CENTER_US);
      en_act_reg  <= 1'b0;
      pwm_reg     <= 1'b0;
    end else begin
      if (wr_sel) pending_reg <= clamped;
      if (fb) begin
        active_reg <= pending_reg;
        en_act_reg <= ch_en;
      end
      pwm_reg <= pwm_next;
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator: shared microsecond prescaler and frame counter,
// write decode and frame-boundary strobe feeding one channel instance per output.
module servo_pwm_multi
  import servo_pwm_pkg::*;
#(
  parameter int unsigned NUM_CH     = DEF_NUM_CH,
  parameter int unsigned CLK_PER_US = DEF_CLK_PER_US,
  parameter int unsigned FRAME_US   = DEF_FRAME_US,
  parameter int unsigned MIN_US     = DEF_MIN_US,
  parameter int unsigned MAX_US     = DEF_MAX_US,
  parameter int unsigned CENTER_US  = DEF_CENTER_US,
  parameter int unsigned STAGGER_US = DEF_STAGGER_US,
  parameter int unsigned US_W       = DEF_US_W
) (
  input  logic              clk,
  input  logic              rst_n,
  servo_pwm_multi_if.slave  wr,
  input  logic [NUM_CH-1:0] ch_en,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic [US_W-1:0]   cur_us
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PRE_W = $clog2(CLK_PER_US);

  if ((NUM_CH - 1) * STAGGER_US + MAX_US >= FRAME_US) begin : g_bad_frame
    $error("servo_pwm_multi: staggered pulses do not fit inside the frame");
  end
  if (NUM_CH < 1 || NUM_CH > 16 || CLK_PER_US < 2) begin : g_bad_params
    $error("servo_pwm_multi: NUM_CH must be 1..16 and CLK_PER_US at least 2");
  end

  logic [PRE_W-1:0] pre_cnt_reg;
  logic [PRE_W-1:0] pre_cnt_next;
  logic [US_W-1:0]  us_cnt_reg;
  logic [US_W-1:0]  us_cnt_next;
  logic             frame_start_reg;
  logic             us_tick;
  logic             fb;

  assign us_tick = (pre_cnt_reg == PRE_W'(CLK_PER_US - 1));
  assign fb      = us_tick && (us_cnt_reg == US_W'(FRAME_US - 1));

  always_comb begin
    pre_cnt_next = pre_cnt_reg + 1'b1;
    us_cnt_next  = us_cnt_reg;
    if (us_tick) begin
      pre_cnt_next = '0;
      us_cnt_next  = fb ? '0 : us_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_reg     <= '0;
      us_cnt_reg      <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      pre_cnt_reg     <= pre_cnt_next;
      us_cnt_reg      <= us_cnt_next;
      frame_start_reg <= fb;
    end
  end

  assign frame_start = frame_start_reg;
  assign cur_us      = us_cnt_reg;

  // Out-of-range channel numbers match no decoder, so such writes are dropped
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic wr_sel;
    assign wr_sel = wr.wr_en && (wr.wr_ch == CH_W'(gi));

    servo_pwm_channel #(
      .US_W      (US_W),
      .MIN_US    (MIN_US),
      .MAX_US    (MAX_US),
      .CENTER_US (CENTER_US),
      .OFF_US    (gi * STAGGER_US)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .us_cnt (us_cnt_reg),
      .fb     (fb),
      .wr_sel (wr_sel),
      .wr_us  (wr.wr_us),
      .ch_en  (ch_en[gi]),
      .pwm    (pwm_out[gi])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Directed bench for servo_pwm_multi with a shortened frame (2 clk/us, 100 us frame,
// 25 us stagger): table of width writes plus hand sequences for frame-edge corner cases.
module tb_servo_pwm_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ch_en;
  logic [2:0]  pwm_out;
  logic        frame_start;
  logic [15:0] cur_us;

  servo_pwm_multi_if #(.NUM_CH(3), .US_W(16)) wr_bus ();

  servo_pwm_multi #(
    .NUM_CH(3), .CLK_PER_US(2), .FRAME_US(100), .MIN_US(10), .MAX_US(20),
    .CENTER_US(15), .STAGGER_US(25), .US_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr_bus), .ch_en(ch_en),
    .pwm_out(pwm_out), .frame_start(frame_start), .cur_us(cur_us)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit do_wr;
    int ch;
    int us;
    int exp0;
    int exp1;
    int exp2;
  } vec_t;

  vec_t vecs[8];
  int checks = 0;
  int passes = 0;
  int meas_hi[3];
  int meas_rise[3];
  int meas_ovl;
  int meas_fs;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic wait_fs();
    int n = 0;
    while (!frame_start && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("frame_start_seen", int'(frame_start), 1);
  endtask

  // Samples one full 200-clk frame starting at the frame_start cycle.
  task automatic measure(input int drop_idx);
    wait_fs();
    for (int k = 0; k < 3; k++) begin
      meas_hi[k]   = 0;
      meas_rise[k] = -1;
    end
    meas_ovl = 0;
    meas_fs  = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == drop_idx) ch_en[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (pwm_out[k]) begin
          meas_hi[k]++;
          if (meas_rise[k] < 0) meas_rise[k] = i;
        end
      end
      if ($countones(pwm_out) > 1) meas_ovl++;
      if (frame_start) meas_fs++;
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string tag, input int e0, input int e1, input int e2);
    int e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    $display("%s: widths %0d/%0d/%0d rises %0d/%0d/%0d", tag,
             meas_hi[0], meas_hi[1], meas_hi[2], meas_rise[0], meas_rise[1], meas_rise[2]);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_width%0d", tag, k), meas_hi[k], e[k]);
      chk($sformatf("%s_rise%0d", tag, k), meas_rise[k], (e[k] > 0) ? (k * 50 + 1) : -1);
    end
    chk($sformatf("%s_overlap", tag), meas_ovl, 0);
    chk($sformatf("%s_fs_count", tag), meas_fs, 1);
  endtask

  task automatic do_write(input int ch, input int us);
    @(negedge clk);
    wr_bus.wr_en = 1'b1;
    wr_bus.wr_ch = 2'(ch);
    wr_bus.wr_us = 16'(us);
    @(negedge clk);
    wr_bus.wr_en = 1'b0;
  endtask

  task automatic count_until_fs(input string tag);
    int n  = 0;
    int hi = 0;
    while (!frame_start && n < 500) begin
      if (pwm_out != 3'b000) hi++;
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s_first_fb_clks", tag), n, 200);
    chk($sformatf("%s_pwm_low_clks", tag), hi, 0);
  endtask

  initial begin
    // widths in clks after each write; channel state carries over between rows
    vecs[0] = '{1'b0, 0, 0,  30, 30, 30};
    vecs[1] = '{1'b1, 1, 5,  30, 20, 30};
    vecs[2] = '{1'b1, 1, 50, 30, 40, 30};
    vecs[3] = '{1'b1, 1, 12, 30, 24, 30};
    vecs[4] = '{1'b1, 3, 19, 30, 24, 30};
    vecs[5] = '{1'b1, 0, 20, 40, 24, 30};
    vecs[6] = '{1'b1, 2, 10, 40, 24, 20};
    vecs[7] = '{1'b1, 0, 10, 20, 24, 20};

    rst_n        = 1'b0;
    ch_en        = 3'b111;
    wr_bus.wr_en = 1'b0;
    wr_bus.wr_ch = '0;
    wr_bus.wr_us = '0;
    repeat (3) @(negedge clk);
    chk("reset_pwm", int'(pwm_out), 0);
    chk("reset_fs", int'(frame_start), 0);
    chk("reset_cur_us", int'(cur_us), 0);
    rst_n = 1'b1;
    count_until_fs("init");
    chk("fs_cur_us", int'(cur_us), 0);

    for (int v = 0; v < 8; v++) begin
      $display("vec %0d: write=%0d ch=%0d us=%0d", v, vecs[v].do_wr, vecs[v].ch, vecs[v].us);
      if (vecs[v].do_wr) do_write(vecs[v].ch, vecs[v].us);
      measure(-1);
      check_frame($sformatf("vec%0d", v), vecs[v].exp0, vecs[v].exp1, vecs[v].exp2);
    end

    // ch1 still at 12 us; bring it to 10 us, then two writes to ch2 in one frame
    do_write(1, 10);
    measure(-1);
    check_frame("ch1_10us", 20, 20, 20);
    @(negedge clk);
    wr_bus.wr_en = 1'b1; wr_bus.wr_ch = 2'd2; wr_bus.wr_us = 16'd20;
    @(negedge clk);
    wr_bus.wr_us = 16'd11;
    @(negedge clk);
    wr_bus.wr_en = 1'b0;
    measure(-1);
    check_frame("last_wins", 20, 20, 22);

    // write landing on the frame-boundary edge itself
    do_write(0, 15);
    wait_fs();
    repeat (199) @(negedge clk);
    chk("pre_fb_cur_us", int'(cur_us), 99);
    wr_bus.wr_en = 1'b1; wr_bus.wr_ch = 2'd0; wr_bus.wr_us = 16'd18;
    @(negedge clk);
    wr_bus.wr_en = 1'b0;
    chk("collision_fs", int'(frame_start), 1);
    measure(-1);
    check_frame("collision_old", 30, 20, 22);
    measure(-1);
    check_frame("collision_new", 36, 20, 22);

    // drop ch2 enable in the middle of its pulse
    measure(110);
    check_frame("en_drop_cur", 36, 20, 22);
    measure(-1);
    check_frame("en_drop_next", 36, 20, 0);

    // async reset in the middle of ch0's pulse
    wait_fs();
    repeat (20) @(negedge clk);
    chk("pre_rst_pwm0", int'(pwm_out[0]), 1);
    chk("pre_rst_cur_us", int'(cur_us), 10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pwm", int'(pwm_out), 0);
    chk("async_rst_cur_us", int'(cur_us), 0);
    chk("async_rst_fs", int'(frame_start), 0);
    ch_en = 3'b111;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    count_until_fs("rerst");
    measure(-1);
    check_frame("after_rst", 30, 30, 30);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/servo_pwm_multi.md
Name: servo_pwm_multi

Overview:
- Parametrised N-channel servo PWM generator running from one system clock (27 MHz in current builds).
- A shared microsecond timebase drives a repeating frame; each channel emits one high pulse per frame.
- Pulse width is programmed in microseconds through a single write port, clamped to the servo-safe range, and applied glitch-free at the frame boundary.
- Per-channel enable and an optional per-channel start stagger spread supply current; the block sits between control logic and the servo output pins.

Parameters:
- NUM_CH, 3, number of servo channels (1..16).
- CLK_PER_US, 27, clock cycles per microsecond (>=2).
- FRAME_US, 20000, frame period in microseconds.
- MIN_US, 1000, minimum legal pulse width in microseconds.
- MAX_US, 2000, maximum legal pulse width in microseconds.
- CENTER_US, 1500, reset pulse width in microseconds.
- STAGGER_US, 0, start offset between adjacent channels; channel k starts at k*STAGGER_US.
- US_W, 16, width of all microsecond quantities.
- Legality constraint: (NUM_CH-1)*STAGGER_US + MAX_US < FRAME_US. Elaboration-time assertion on violation.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  one-cycle write strobe.
- wr_ch  in  $clog2(NUM_CH) (min 1)  target channel.
- wr_us  in  US_W  requested pulse width in microseconds.
- ch_en  in  NUM_CH  per-channel enable, sampled at frame boundary.
- pwm_out  out  NUM_CH  servo pulse outputs.
- frame_start  out  1  one-cycle strobe at frame boundary.
- cur_us  out  US_W  current frame position in microseconds.

Behaviour:
- Reset (async assert, sync release):
  - Prescaler and us_cnt go to 0; pwm_out and frame_start go to 0.
  - pending[k] and active[k] go to CENTER_US; en_act[k] goes to 0.
  - Outputs therefore stay low until the first frame boundary.
- Prescaler:
  - pre_cnt counts 0..CLK_PER_US-1 and wraps.
  - us_tick is combinational: pre_cnt==CLK_PER_US-1.
- Frame counter:
  - us_cnt increments on us_tick and wraps FRAME_US-1 -> 0.
  - cur_us = us_cnt.
- Frame boundary (FB): the clock edge where us_tick is high and us_cnt==FRAME_US-1. At that edge:
  - active[k] <= pending[k];
  - en_act <= ch_en;
  - frame_start <= 1 for exactly one cycle, coincident with us_cnt==0, pre_cnt==0.
- Write:
  - On wr_en, pending[wr_ch] <= clamp(wr_us, MIN_US, MAX_US), taking effect the next cycle.
  - wr_ch >= NUM_CH: write is ignored and no state changes.
  - Writes never touch active directly.
- Simultaneous write and FB: active loads the old pending value; the new value lands in pending and applies at the following FB.
  - Multiple writes within one frame: last write wins.
- Output generation:
  - off_k = k*STAGGER_US is a constant.
  - pwm_out[k] <= en_act[k] && (us_cnt >= off_k) && (us_cnt < off_k + active[k]), registered.
  - One-cycle latency versus us_cnt. The comparison uses post-FB values, so the first frame after FB already uses the new width.
  - The pulse is high for exactly active[k]*CLK_PER_US clocks per frame; there is no partial or double pulse across FB.
- ch_en changes mid-frame have no effect until FB.
- All arithmetic is unsigned, US_W bits; no overflow, guaranteed by the legality constraint.
- Reset mid-pulse: pwm_out drops immediately (async). After release, outputs stay low until the first FB, about one frame.

Decomposition:
- Package servo_pwm_pkg holds:
  - default constants (27 MHz CLK_PER_US, 20 ms frame, 1000/1500/2000 us limits);
  - function clamp_us(val, lo, hi).
- Sub-module servo_pwm_channel, instantiated NUM_CH times from a generate loop. It contains the pending/active/en_act registers, the clamp, and the window comparator. Its inputs are us_cnt, fb and the decoded write strobe.
- The top level holds the prescaler, us_cnt, FB detection, write decode and frame_start.

Test Plan:
Sim overrides: CLK_PER_US=2, FRAME_US=100, MIN_US=10, MAX_US=20, CENTER_US=15, NUM_CH=3.
- Reset check: release rst_n with ch_en=3'b111.
  - pwm_out stays 0 for the first 200 clks.
  - After the first frame_start, each channel is high for 30 clks per 200-clk frame.
- Clamp: write ch1 with wr_us=5, then 50, then 12 in successive frames.
  - Pulse widths after each FB are 20, 40, then 24 clks.
- FB collision: pulse wr_en (ch0, 18) in the same cycle as FB.
  - The next frame keeps 15 us (30 clks); the frame after shows 18 us (36 clks).
- Stagger: STAGGER_US=25, all channels at 10 us.
  - Rising edges occur at us_cnt 0, 25 and 50, plus one clk latency.
  - Pulses are each 20 clks and never overlap.
- Enable and bad channel:
  - Drop ch_en[2] mid-pulse: the current pulse completes, and ch2 is silent from the next FB.
  - wr_ch=3 with NUM_CH=3 changes no width.
- Async reset mid-pulse: assert rst_n low while pwm_out[0]=1.
  - pwm_out goes 0 without waiting for a clock edge.
  - cur_us returns to 0.
